// File: rtl/ball_motion_ctl_pkg.sv
// Shared definitions for the ball-motion engine: FSM encoding, direction bit
// positions in btn/blocked, and velocity width derivation.
package ball_motion_ctl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      UPD_X = 2'd1,
      UPD_Y = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;

   // Velocity carries 7 integer bits above the fraction (covers +/-V_MAX plus headroom).
   function automatic int v_width(input int frac_w);
      return frac_w + 7;
   endfunction

endpackage

// File: rtl/ball_motion_ctl_if.sv
// Control/status bundle between the input blocks, the motion engine and the renderer.
interface ball_motion_ctl_if #(
   parameter int X_W   = 10,
   parameter int Y_W   = 9,
   parameter int ACC_W = 9
);
   logic             mode;
   logic             recenter;
   logic [3:0]       btn;
   logic [ACC_W-1:0] accel_x;
   logic [ACC_W-1:0] accel_y;
   logic [3:0]       blocked;
   logic [X_W-1:0]   x_out;
   logic [Y_W-1:0]   y_out;
   logic             upd;
   logic             moving;

   modport master (
      output mode, recenter, btn, accel_x, accel_y, blocked,
      input  x_out, y_out, upd, moving
   );

   modport slave (
      input  mode, recenter, btn, accel_x, accel_y, blocked,
      output x_out, y_out, upd, moving
   );
endinterface

// File: rtl/axis_integrator.sv
// One axis of the fixed-point integrator: acceleration select, friction,
// velocity saturation and position clamping against walls and screen edges.
module axis_integrator
   import ball_motion_ctl_pkg::*;
#(
   parameter int P_W       = 10,
   parameter int MAX       = 319,
   parameter int START     = 8,
   parameter int ACC_W     = 9,
   parameter int ACC_ZERO  = 256,
   parameter int DEAD_ZONE = 16,
   parameter int ACC_SHIFT = 4,
   parameter int A_BTN     = 2,
   parameter int FRAC_W    = 4,
   parameter int V_MAX     = 48,
   localparam int V_W      = v_width(FRAC_W),
   localparam int PF_W     = P_W + FRAC_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    rcn,
   input  logic                    clr_v,
   input  logic                    mode,
   input  logic                    btn_pos,
   input  logic                    btn_neg,
   input  logic [ACC_W-1:0]        sample,
   input  logic                    blk_pos,
   input  logic                    blk_neg,
   output logic [PF_W-1:0]         p,
   output logic signed [V_W-1:0]   v
);

   localparam int EW = ((PF_W > V_W) ? PF_W : V_W) + 2;
   localparam logic signed [EW-1:0]    ZERO = '0;
   localparam logic signed [EW-1:0]    ONE  = EW'(1);
   localparam logic signed [EW-1:0]    VMX  = EW'(V_MAX);
   localparam logic signed [EW-1:0]    PMX  = EW'(MAX << FRAC_W);
   localparam logic signed [ACC_W:0]   DZ   = (ACC_W+1)'(DEAD_ZONE);
   localparam logic [PF_W-1:0]         P_ST = PF_W'(START << FRAC_W);

   logic signed [ACC_W:0]  d;
   logic signed [EW-1:0]   a, vb, vs, pc;
   logic [PF_W-1:0]        p_nx;
   logic signed [V_W-1:0]  v_nx;

   assign d = $signed({1'b0, sample}) - $signed((ACC_W+1)'(ACC_ZERO));

   always_comb begin
      a = ZERO;
      if (mode) begin
         if (!(d < DZ && d > -DZ))
            a = EW'(d >>> ACC_SHIFT);
      end else if (btn_pos && !btn_neg) begin
         a = EW'(A_BTN);
      end else if (btn_neg && !btn_pos) begin
         a = -EW'(A_BTN);
      end

      // Mode switch discards the old velocity before this update integrates.
      vb = clr_v ? ZERO : EW'(v);
      if (a != ZERO)     vs = vb + a;
      else if (vb > ZERO) vs = vb - ONE;
      else if (vb < ZERO) vs = vb + ONE;
      else               vs = vb;
      if (vs > VMX)       vs = VMX;
      else if (vs < -VMX) vs = -VMX;

      pc   = $signed(EW'(p)) + vs;
      p_nx = p;
      v_nx = V_W'(vs);
      if ((vs > ZERO && blk_pos) || (vs < ZERO && blk_neg)) begin
         v_nx = '0;
      end else if (pc < ZERO) begin
         p_nx = '0;
         v_nx = '0;
      end else if (pc > PMX) begin
         p_nx = PF_W'(PMX);
         v_nx = '0;
      end else begin
         p_nx = PF_W'(pc);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || rcn) begin
         p <= P_ST;
         v <= '0;
      end else if (en) begin
         p <= p_nx;
         v <= v_nx;
      end
   end

endmodule

// File: rtl/ball_motion_ctl.sv
// Ball-motion engine top: physics-tick prescaler, X-then-Y update FSM,
// control-mode latch, and the two axis integrators.
module ball_motion_ctl
   import ball_motion_ctl_pkg::*;
#(
   parameter int X_W       = 10,
   parameter int Y_W       = 9,
   parameter int X_MAX     = 319,
   parameter int Y_MAX     = 239,
   parameter int X_START   = 8,
   parameter int Y_START   = 8,
   parameter int ACC_W     = 9,
   parameter int ACC_ZERO  = 256,
   parameter int DEAD_ZONE = 16,
   parameter int ACC_SHIFT = 4,
   parameter int A_BTN     = 2,
   parameter int FRAC_W    = 4,
   parameter int V_MAX     = 48,
   parameter int TICK_DIV  = 1000000
) (
   input logic              clk,
   input logic              reset,
   ball_motion_ctl_if.slave bus
);

   localparam int V_W   = v_width(FRAC_W);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   state_t               state_q, state_nx;
   logic [CNT_W-1:0]     cnt_q;
   logic                 tick, mode_q, clr_y_q, mode_chg, mode_ax;
   logic                 en_x, en_y, clr_x;
   logic [X_W+FRAC_W-1:0] p_x;
   logic [Y_W+FRAC_W-1:0] p_y;
   logic signed [V_W-1:0] v_x, v_y;

   assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (reset)             state_q <= IDLE;
      else if (bus.recenter) state_q <= IDLE;
      else                   state_q <= state_nx;
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         IDLE:    if (tick) state_nx = UPD_X;
         UPD_X:   state_nx = UPD_Y;
         UPD_Y:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      en_x    = (state_q == UPD_X);
      en_y    = (state_q == UPD_Y);
      bus.upd = (state_q == DONE) && !bus.recenter;
   end

   // Mode is captured in UPD_X; Y reuses the captured value and clear decision.
   assign mode_chg = (bus.mode != mode_q);
   assign clr_x    = en_x && mode_chg;
   assign mode_ax  = en_x ? bus.mode : mode_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         clr_y_q <= 1'b0;
      end else begin
         cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
         if (en_x) begin
            mode_q  <= bus.mode;
            clr_y_q <= mode_chg;
         end
      end
   end

   axis_integrator #(
      .P_W(X_W), .MAX(X_MAX), .START(X_START), .ACC_W(ACC_W), .ACC_ZERO(ACC_ZERO),
      .DEAD_ZONE(DEAD_ZONE), .ACC_SHIFT(ACC_SHIFT), .A_BTN(A_BTN), .FRAC_W(FRAC_W),
      .V_MAX(V_MAX)
   ) u_ax (
      .clk(clk), .reset(reset), .en(en_x), .rcn(bus.recenter), .clr_v(clr_x),
      .mode(mode_ax), .btn_pos(bus.btn[DIR_RIGHT]), .btn_neg(bus.btn[DIR_LEFT]),
      .sample(bus.accel_x), .blk_pos(bus.blocked[DIR_RIGHT]),
      .blk_neg(bus.blocked[DIR_LEFT]), .p(p_x), .v(v_x)
   );

   axis_integrator #(
      .P_W(Y_W), .MAX(Y_MAX), .START(Y_START), .ACC_W(ACC_W), .ACC_ZERO(ACC_ZERO),
      .DEAD_ZONE(DEAD_ZONE), .ACC_SHIFT(ACC_SHIFT), .A_BTN(A_BTN), .FRAC_W(FRAC_W),
      .V_MAX(V_MAX)
   ) u_ay (
      .clk(clk), .reset(reset), .en(en_y), .rcn(bus.recenter), .clr_v(clr_y_q),
      .mode(mode_ax), .btn_pos(bus.btn[DIR_DOWN]), .btn_neg(bus.btn[DIR_UP]),
      .sample(bus.accel_y), .blk_pos(bus.blocked[DIR_DOWN]),
      .blk_neg(bus.blocked[DIR_UP]), .p(p_y), .v(v_y)
   );

   assign bus.x_out  = p_x[X_W+FRAC_W-1:FRAC_W];
   assign bus.y_out  = p_y[Y_W+FRAC_W-1:FRAC_W];
   assign bus.moving = (v_x != '0) || (v_y != '0);

endmodule

// File: tb/tb_ball_motion_ctl.sv
// Scoreboard bench for ball_motion_ctl: each update's expected ball state is
// pushed when its stimulus is driven and popped when the upd pulse arrives.
module tb_ball_motion_ctl;
   import ball_motion_ctl_pkg::*;

   localparam int TD = 4, FW = 4, AB = 2, VM = 48;
   localparam int XM = 319, YM = 239, XS = 8, YS = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   ball_motion_ctl_if #(.X_W(10), .Y_W(9), .ACC_W(9)) bus();

   ball_motion_ctl #(.TICK_DIV(TD), .FRAC_W(FW), .A_BTN(AB), .V_MAX(VM)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      int x; int y; int mv; int vx; int vy;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   mpx, mvx, mpy, mvy;
   bit   m_mode;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int accel(input bit md, input bit bp, input bit bn, input int s);
      int d;
      if (md) begin
         d = s - 256;
         if (d > -16 && d < 16) return 0;
         return d >>> 4;
      end
      if (bp && !bn) return AB;
      if (bn && !bp) return -AB;
      return 0;
   endfunction

   function automatic void axis(inout int p, inout int v, input int a, input bit clr,
                                input bit bp, input bit bn, input int mx);
      int vn, pc;
      vn = clr ? 0 : v;
      if (a != 0)      vn = vn + a;
      else if (vn > 0) vn = vn - 1;
      else if (vn < 0) vn = vn + 1;
      if (vn > VM)  vn = VM;
      if (vn < -VM) vn = -VM;
      pc = p + vn;
      if ((vn > 0 && bp) || (vn < 0 && bn)) vn = 0;
      else if (pc < 0) begin p = 0; vn = 0; end
      else if (pc > mx * 16) begin p = mx * 16; vn = 0; end
      else p = pc;
      v = vn;
   endfunction

   task automatic step(input string tag, input bit md, input logic [3:0] b, input int ax,
                       input int ay, input logic [3:0] blk, output int waited);
      exp_t e;
      bit   clr;
      bus.mode    = md;
      bus.btn     = b;
      bus.accel_x = 9'(ax);
      bus.accel_y = 9'(ay);
      bus.blocked = blk;
      clr    = (md != m_mode);
      m_mode = md;
      axis(mpx, mvx, accel(md, b[3], b[2], ax), clr, blk[3], blk[2], XM);
      axis(mpy, mvy, accel(md, b[1], b[0], ay), clr, blk[1], blk[0], YM);
      e.x = mpx / 16; e.y = mpy / 16; e.mv = (mvx != 0 || mvy != 0) ? 1 : 0;
      e.vx = mvx; e.vy = mvy;
      sb.push_back(e);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.upd && waited < 20);
      if (!bus.upd) chk({tag, " upd timeout"}, 0, 1);
      e = sb.pop_front();
      chk({tag, " x_out"}, int'(bus.x_out), e.x);
      chk({tag, " y_out"}, int'(bus.y_out), e.y);
      chk({tag, " moving"}, int'(bus.moving), e.mv);
      chk({tag, " v_x"}, int'(dut.u_ax.v), e.vx);
      chk({tag, " v_y"}, int'(dut.u_ay.v), e.vy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, nu;
      bus.mode = 1'b0; bus.recenter = 1'b0; bus.btn = '0; bus.blocked = '0;
      bus.accel_x = 9'd256; bus.accel_y = 9'd256;
      mpx = XS * 16; mpy = YS * 16; mvx = 0; mvy = 0; m_mode = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset x_out", int'(bus.x_out), XS);
      chk("reset y_out", int'(bus.y_out), YS);
      chk("reset upd", int'(bus.upd), 0);
      chk("reset moving", int'(bus.moving), 0);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         step("idle", 1'b0, 4'b0000, 256, 256, 4'b0000, w);
         if (i > 0) chk("idle upd period", w, TD);
      end

      for (int i = 0; i < 3; i++) step("btn right", 1'b0, 4'b1000, 256, 256, 4'b0000, w);
      for (int i = 0; i < 8; i++) step("btn release", 1'b0, 4'b0000, 256, 256, 4'b0000, w);

      for (int i = 0; i < 2; i++) step("tilt dead zone", 1'b1, 4'b0000, 266, 256, 4'b0000, w);
      for (int i = 0; i < 6; i++) step("tilt x sat", 1'b1, 4'b0000, 416, 256, 4'b0000, w);
      for (int i = 0; i < 5; i++) step("tilt y top", 1'b1, 4'b0000, 256, 100, 4'b0000, w);
      for (int i = 0; i < 115; i++) step("tilt x edge", 1'b1, 4'b0000, 416, 300, 4'b0000, w);

      // Recenter pulse while the Y axis is updating.
      w = 0;
      while (dut.state_q != UPD_Y && w < 10) begin
         @(negedge clk);
         w++;
      end
      chk("recenter in UPD_Y", int'(dut.state_q == UPD_Y), 1);
      bus.recenter = 1'b1;
      @(negedge clk);
      bus.recenter = 1'b0;
      chk("recenter x_out", int'(bus.x_out), XS);
      chk("recenter y_out", int'(bus.y_out), YS);
      chk("recenter moving", int'(bus.moving), 0);
      chk("recenter state", int'(dut.state_q), int'(IDLE));
      nu = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.upd) nu++;
         @(negedge clk);
      end
      chk("recenter no upd", nu, 0);
      mpx = XS * 16; mpy = YS * 16; mvx = 0; mvy = 0;
      step("after recenter", 1'b1, 4'b0000, 416, 300, 4'b0000, w);

      for (int i = 0; i < 15; i++) step("left to edge", 1'b0, 4'b0100, 256, 256, 4'b0000, w);
      for (int i = 0; i < 6; i++) step("right free", 1'b0, 4'b1000, 256, 256, 4'b0000, w);
      for (int i = 0; i < 3; i++) step("right blocked", 1'b0, 4'b1000, 256, 256, 4'b1000, w);
      for (int i = 0; i < 3; i++) step("down blocked", 1'b0, 4'b0010, 256, 256, 4'b0010, w);

      for (int i = 0; i < 10; i++) step("build v20", 1'b0, 4'b1010, 256, 256, 4'b0000, w);
      step("mode toggle", 1'b1, 4'b0000, 256, 256, 4'b0000, w);
      step("tilt after toggle", 1'b1, 4'b0000, 416, 256, 4'b0000, w);
      step("toggle back", 1'b0, 4'b1000, 256, 256, 4'b0000, w);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
